// File: rtl/ay_seq_pkg.sv
// rtl/ay_seq_pkg.sv - shared types and constants for the AY bus sequencer
// Contents: FSM state enum, AY bus op codes, config/SAA-select byte constants,
// default strobe timing, and a config-byte decode helper. No ports.

package ay_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_STROBE    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } ay_state_t;

    // Encoded as {bdir, bc1} once qualified by asel.
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_READ    = 2'b01,
        OP_DATA_WR = 2'b10,
        OP_ADDR_WR = 2'b11
    } ay_op_t;

    localparam logic [7:0] SAA_SEL_VALUE = 8'hF7;
    localparam logic [7:0] CFG_MASK      = 8'hF8;

    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 4;
    localparam int DEF_T_HOLD  = 2;

    localparam int CNT_W = 8;

    // Address-register values F8..FF are intercepted as sequencer config.
    function automatic logic is_cfg_value(input logic [7:0] v);
        return (v & CFG_MASK) == CFG_MASK;
    endfunction

endpackage

// File: rtl/ay_sync.sv
// rtl/ay_sync.sv - two-flop single-bit synchroniser
// Ports: fclk (clock), ayres_n (async active-low reset), d (async input),
// q (synchronised output, resets to 0).

module ay_sync (
    input  logic fclk,
    input  logic ayres_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ay_bus_sequencer.sv
// rtl/ay_bus_sequencer.sv - translates raw AY bus cycles into timed YM/SAA chip cycles
// Ports: fclk/ayres_n clock and async reset; bdir/bc1/asel/ayd_in raw AY bus in,
// ayd_out/ayd_oe read data back to the AY bus; mode_enable_saa/mode_enable_ymfm
// static mode straps; d_in/d_out/d_oe internal chip data bus; ymcs1_n/ymcs2_n/
// ymrd_n/ymwr_n/yma0 YM chip controls; saacs_n/saawr_n/saaa0 SAA chip controls;
// busy high whenever the sequencer is not idle.

module ay_bus_sequencer
    import ay_seq_pkg::*;
#(
    // All three must be at least 1.
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD  = DEF_T_HOLD
) (
    input  logic       fclk,
    input  logic       ayres_n,
    input  logic       bdir,
    input  logic       bc1,
    input  logic       asel,
    input  logic [7:0] ayd_in,
    output logic [7:0] ayd_out,
    output logic       ayd_oe,
    input  logic       mode_enable_saa,
    input  logic       mode_enable_ymfm,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       ymcs1_n,
    output logic       ymcs2_n,
    output logic       ymrd_n,
    output logic       ymwr_n,
    output logic       yma0,
    output logic       saacs_n,
    output logic       saawr_n,
    output logic       saaa0,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

    logic   bdir_s, bc1_s, asel_s;
    ay_op_t code;

    ay_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ay_op_t           op_q, op_d;
    logic [7:0]       lat_q, lat_d;
    logic             chip_sel_q, chip_sel_d;
    logic             rd_stat_q, rd_stat_d;
    logic             saa_mode_q, saa_mode_d;
    logic [7:0]       rd_latch_q, rd_latch_d;
    logic             start;

    logic       active_d, pulse_d, is_rd_d, ym_d, saa_d;
    logic       ymcs1_n_d, ymcs2_n_d, ymrd_n_d, ymwr_n_d, yma0_d;
    logic       saacs_n_d, saawr_n_d, saaa0_d, d_oe_d;
    logic [7:0] d_out_d;

    ay_sync u_sync_bdir (.fclk(fclk), .ayres_n(ayres_n), .d(bdir), .q(bdir_s));
    ay_sync u_sync_bc1  (.fclk(fclk), .ayres_n(ayres_n), .d(bc1),  .q(bc1_s));
    ay_sync u_sync_asel (.fclk(fclk), .ayres_n(ayres_n), .d(asel), .q(asel_s));

    assign code = asel_s ? ay_op_t'({bdir_s, bc1_s}) : OP_IDLE;

    always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_IDLE;
            lat_q      <= 8'h00;
            chip_sel_q <= 1'b0;
            rd_stat_q  <= 1'b0;
            saa_mode_q <= 1'b0;
            rd_latch_q <= 8'hFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            lat_q      <= lat_d;
            chip_sel_q <= chip_sel_d;
            rd_stat_q  <= rd_stat_d;
            saa_mode_q <= saa_mode_d;
            rd_latch_q <= rd_latch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        lat_d      = lat_q;
        chip_sel_d = chip_sel_q;
        rd_stat_d  = rd_stat_q;
        saa_mode_d = saa_mode_q;
        rd_latch_d = rd_latch_q;
        start      = 1'b0;

        case (state_q)
            ST_IDLE: start = (code != OP_IDLE);
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = LD_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    if (op_q == OP_READ && !saa_mode_q) begin
                        rd_latch_d = d_in;
                    end
                    state_d = ST_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // A new, different code with no idle gap starts the next op.
                if (code == OP_IDLE) begin
                    state_d = ST_IDLE;
                end else begin
                    start = (code != op_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            op_d  = code;
            lat_d = ayd_in;
            if (code == OP_ADDR_WR && is_cfg_value(ayd_in)) begin
                chip_sel_d = ayd_in[0] & mode_enable_ymfm;
                rd_stat_d  = ayd_in[1];
                saa_mode_d = 1'b0;
                state_d    = ST_WAIT_IDLE;
            end else if (code == OP_ADDR_WR && ayd_in == SAA_SEL_VALUE && mode_enable_saa) begin
                saa_mode_d = 1'b1;
                state_d    = ST_WAIT_IDLE;
            end else begin
                // The SAA is write-only: a read in SAA mode runs the timing
                // with no chip activity and returns all-ones.
                if (code == OP_READ && saa_mode_q) begin
                    rd_latch_d = 8'hFF;
                end
                state_d = ST_SETUP;
                cnt_d   = LD_SETUP;
            end
        end
    end

    // Chip controls are decoded from next-state values and registered so the
    // pins are glitch-free yet change on the same edge as the state.
    always_comb begin
        active_d  = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        pulse_d   = (state_d == ST_STROBE);
        is_rd_d   = (op_d == OP_READ);
        ym_d      = active_d && !saa_mode_d;
        saa_d     = active_d && saa_mode_d && !is_rd_d;

        ymcs1_n_d = !(ym_d && !chip_sel_d);
        ymcs2_n_d = !(ym_d && chip_sel_d);
        ymwr_n_d  = !(ym_d && pulse_d && !is_rd_d);
        ymrd_n_d  = !(ym_d && pulse_d && is_rd_d);
        yma0_d    = 1'b0;
        if (ym_d) begin
            case (op_d)
                OP_ADDR_WR: yma0_d = 1'b0;
                OP_DATA_WR: yma0_d = 1'b1;
                default:    yma0_d = !rd_stat_d;
            endcase
        end

        saacs_n_d = !saa_d;
        saawr_n_d = !(saa_d && pulse_d);
        saaa0_d   = saa_d && (op_d == OP_ADDR_WR);

        d_oe_d    = active_d && !is_rd_d;
        d_out_d   = d_oe_d ? lat_d : 8'h00;
    end

    always_ff @(posedge fclk or negedge ayres_n) begin
        if (!ayres_n) begin
            ymcs1_n <= 1'b1;
            ymcs2_n <= 1'b1;
            ymwr_n  <= 1'b1;
            ymrd_n  <= 1'b1;
            yma0    <= 1'b0;
            saacs_n <= 1'b1;
            saawr_n <= 1'b1;
            saaa0   <= 1'b0;
            d_oe    <= 1'b0;
            d_out   <= 8'h00;
        end else begin
            ymcs1_n <= ymcs1_n_d;
            ymcs2_n <= ymcs2_n_d;
            ymwr_n  <= ymwr_n_d;
            ymrd_n  <= ymrd_n_d;
            yma0    <= yma0_d;
            saacs_n <= saacs_n_d;
            saawr_n <= saawr_n_d;
            saaa0   <= saaa0_d;
            d_oe    <= d_oe_d;
            d_out   <= d_out_d;
        end
    end

    // Live chip data is only forwarded while a YM read strobe is active.
    assign ayd_out = (state_q == ST_STROBE && !saa_mode_q) ? d_in : rd_latch_q;
    assign ayd_oe  = (state_q != ST_IDLE) && (op_q == OP_READ) && (code == OP_READ);
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// tb/tb_ay_bus_sequencer.sv - scoreboard bench for ay_bus_sequencer

module tb_ay_bus_sequencer;

    logic       fclk = 1'b0;
    logic       ayres_n;
    logic       bdir, bc1, asel;
    logic [7:0] ayd_in;
    logic [7:0] ayd_out;
    logic       ayd_oe;
    logic       mode_enable_saa, mode_enable_ymfm;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;
    logic       ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0;
    logic       saacs_n, saawr_n, saaa0;
    logic       busy;
    logic [7:0] ym_rd_data;

    always #5 fclk = ~fclk;

    // YM chip model: drives read data only while its read strobe is low.
    assign d_in = !ymrd_n ? ym_rd_data : 8'h00;

    ay_bus_sequencer dut (
        .fclk(fclk), .ayres_n(ayres_n),
        .bdir(bdir), .bc1(bc1), .asel(asel), .ayd_in(ayd_in),
        .ayd_out(ayd_out), .ayd_oe(ayd_oe),
        .mode_enable_saa(mode_enable_saa), .mode_enable_ymfm(mode_enable_ymfm),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .ymcs1_n(ymcs1_n), .ymcs2_n(ymcs2_n), .ymrd_n(ymrd_n), .ymwr_n(ymwr_n), .yma0(yma0),
        .saacs_n(saacs_n), .saawr_n(saawr_n), .saaa0(saaa0),
        .busy(busy)
    );

    typedef struct packed {
        logic [1:0] tgt;   // 0 = YM chip 0, 1 = YM chip 1, 2 = SAA
        logic       rd;
        logic       a0;
        logic [7:0] data;
        logic [7:0] len;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [1:0] tgt, input logic rd, input logic a0, input logic [7:0] data);
        exp_t e;
        e.tgt  = tgt;
        e.rd   = rd;
        e.a0   = a0;
        e.data = data;
        e.len  = 8'd4;
        sb_q.push_back(e);
    endtask

    // Monitor: records each chip strobe pulse and checks it against the queue.
    logic       in_pulse = 1'b0;
    int         plen = 0;
    logic [1:0] cap_tgt;
    logic       cap_rd, cap_a0, cap_doe;
    logic [7:0] cap_data;
    exp_t       e_pop;
    int         ncs;
    logic       orphan;

    always @(negedge fclk) begin
        if (!ayres_n) begin
            in_pulse = 1'b0;
            plen     = 0;
        end else begin
            ncs    = int'(!ymcs1_n) + int'(!ymcs2_n) + int'(!saacs_n);
            orphan = ((!ymwr_n || !ymrd_n) && ymcs1_n && ymcs2_n) || (!saawr_n && saacs_n);
            chk("exclusive_cs", {31'd0, (ncs <= 1) && !orphan}, 32'd1);
            if (!ymwr_n || !ymrd_n || !saawr_n) begin
                if (!in_pulse) begin
                    cap_tgt  = !ymcs1_n ? 2'd0 : (!ymcs2_n ? 2'd1 : (!saacs_n ? 2'd2 : 2'd3));
                    cap_rd   = !ymrd_n;
                    cap_a0   = !saacs_n ? saaa0 : yma0;
                    cap_data = cap_rd ? ayd_out : d_out;
                    cap_doe  = d_oe;
                end
                in_pulse = 1'b1;
                plen++;
            end else if (in_pulse) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: tgt %0d data 0x%0h with empty scoreboard", cap_tgt, cap_data);
                end else begin
                    e_pop = sb_q.pop_front();
                    chk("txn_target", {30'd0, cap_tgt}, {30'd0, e_pop.tgt});
                    chk("txn_is_read", {31'd0, cap_rd}, {31'd0, e_pop.rd});
                    chk("txn_a0", {31'd0, cap_a0}, {31'd0, e_pop.a0});
                    chk("txn_data", {24'd0, cap_data}, {24'd0, e_pop.data});
                    chk("txn_d_oe", {31'd0, cap_doe}, {31'd0, !e_pop.rd});
                    chk("txn_strobe_len", plen, {24'd0, e_pop.len});
                end
                in_pulse = 1'b0;
                plen     = 0;
            end
        end
    end

    task automatic bus_set(input logic [1:0] code, input logic [7:0] d);
        @(posedge fclk);
        #1;
        bdir   = code[1];
        bc1    = code[0];
        asel   = (code != 2'b00);
        ayd_in = d;
    endtask

    task automatic ay_write(input logic is_addr, input logic [7:0] d);
        bus_set(is_addr ? 2'b11 : 2'b10, d);
        repeat (14) @(posedge fclk);
        bus_set(2'b00, 8'h00);
        repeat (4) @(posedge fclk);
    endtask

    task automatic ay_read(input logic [7:0] exp_data);
        bus_set(2'b01, 8'h00);
        repeat (13) @(posedge fclk);
        @(negedge fclk);
        chk("read_ayd_oe", {31'd0, ayd_oe}, 32'd1);
        chk("read_ayd_out", {24'd0, ayd_out}, {24'd0, exp_data});
        bus_set(2'b00, 8'h00);
        repeat (4) @(posedge fclk);
    endtask

    int   lows, gap, busy_seen;
    logic prev_cs;
    logic found;

    initial begin
        ayres_n          = 1'b0;
        bdir             = 1'b0;
        bc1              = 1'b0;
        asel             = 1'b0;
        ayd_in           = 8'h00;
        mode_enable_saa  = 1'b1;
        mode_enable_ymfm = 1'b1;
        ym_rd_data       = 8'h00;

        repeat (3) @(posedge fclk);
        @(negedge fclk);
        chk("reset_ymcs1_n", {31'd0, ymcs1_n}, 32'd1);
        chk("reset_ymcs2_n", {31'd0, ymcs2_n}, 32'd1);
        chk("reset_saacs_n", {31'd0, saacs_n}, 32'd1);
        chk("reset_ymwr_n", {31'd0, ymwr_n}, 32'd1);
        chk("reset_ymrd_n", {31'd0, ymrd_n}, 32'd1);
        chk("reset_saawr_n", {31'd0, saawr_n}, 32'd1);
        chk("reset_yma0", {31'd0, yma0}, 32'd0);
        chk("reset_saaa0", {31'd0, saaa0}, 32'd0);
        chk("reset_d_oe", {31'd0, d_oe}, 32'd0);
        chk("reset_d_out", {24'd0, d_out}, 32'd0);
        chk("reset_ayd_oe", {31'd0, ayd_oe}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ayd_out", {24'd0, ayd_out}, 32'hFF);
        @(posedge fclk);
        #1 ayres_n = 1'b1;
        repeat (2) @(posedge fclk);

        // YM chip 0 write (config FE: chip 0, status reads)
        ay_write(1'b1, 8'hFE);
        sb_push(2'd0, 1'b0, 1'b0, 8'h27); ay_write(1'b1, 8'h27);
        sb_push(2'd0, 1'b0, 1'b1, 8'h81); ay_write(1'b0, 8'h81);

        // YM chip 1 read (config FD: chip 1, data reads -> a0=1)
        ay_write(1'b1, 8'hFD);
        ym_rd_data = 8'h3C;
        sb_push(2'd1, 1'b1, 1'b1, 8'h3C); ay_read(8'h3C);

        // SAA select, then address/data writes; SAA read returns FF with no strobe
        ay_write(1'b1, 8'hF7);
        sb_push(2'd2, 1'b0, 1'b1, 8'h5A); ay_write(1'b1, 8'h5A);
        sb_push(2'd2, 1'b0, 1'b0, 8'hC3); ay_write(1'b0, 8'hC3);
        ay_read(8'hFF);

        // YMFM disabled: chip 1 request forced to chip 0, SAA mode cleared
        mode_enable_ymfm = 1'b0;
        ay_write(1'b1, 8'hFF);
        sb_push(2'd0, 1'b0, 1'b0, 8'h10); ay_write(1'b1, 8'h10);
        sb_push(2'd0, 1'b0, 1'b1, 8'h22); ay_write(1'b0, 8'h22);
        mode_enable_saa = 1'b0;
        sb_push(2'd0, 1'b0, 1'b0, 8'hF7); ay_write(1'b1, 8'hF7);
        // rd_stat=1 from config FF -> status read with a0=0
        ym_rd_data = 8'hA5;
        sb_push(2'd0, 1'b1, 1'b0, 8'hA5); ay_read(8'hA5);

        // Back-to-back address then data write with no idle gap
        sb_push(2'd0, 1'b0, 1'b0, 8'h11);
        sb_push(2'd0, 1'b0, 1'b1, 8'h22);
        bus_set(2'b11, 8'h11);
        lows    = 0;
        gap     = 0;
        prev_cs = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge fclk);
            if (i == 6) begin
                bdir   = 1'b1;
                bc1    = 1'b0;
                ayd_in = 8'h22;
            end
            if (!ymcs1_n && prev_cs) lows++;
            if (ymcs1_n && lows == 1) gap++;
            prev_cs = ymcs1_n;
        end
        chk("b2b_cycle_count", lows, 32'd2);
        chk("b2b_cs_gap", gap, 32'd1);
        bus_set(2'b00, 8'h00);
        repeat (4) @(posedge fclk);

        // Reset asserted mid-strobe
        bus_set(2'b11, 8'h33);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge fclk);
            if (!ymwr_n) found = 1'b1;
        end
        chk("rst_strobe_reached", {31'd0, found}, 32'd1);
        @(negedge fclk);
        #2 ayres_n = 1'b0;
        #1;
        chk("rst_ymwr_n", {31'd0, ymwr_n}, 32'd1);
        chk("rst_ymcs1_n", {31'd0, ymcs1_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_d_oe", {31'd0, d_oe}, 32'd0);
        chk("rst_rd_latch", {24'd0, ayd_out}, 32'hFF);
        bdir   = 1'b0;
        bc1    = 1'b0;
        asel   = 1'b0;
        ayd_in = 8'h00;
        repeat (3) @(negedge fclk);
        #2 ayres_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge fclk);
            if (busy) busy_seen++;
        end
        chk("rst_no_resume", busy_seen, 32'd0);

        repeat (5) @(posedge fclk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ay_bus_sequencer.md
AY_BUS_SEQUENCER -- requirements
Module: ay_bus_sequencer

Interface
REQ-001 Parameter T_SETUP, default 2, fclk cycles from cs_n low to strobe low.
REQ-002 Parameter T_PULSE, default 4, fclk cycles of wr_n/rd_n low.
REQ-003 Parameter T_HOLD, default 2, fclk cycles from strobe high to cs_n high.
REQ-004 Clocking: one clock, fclk; reset ayres_n is asynchronous, active-low.
REQ-005 Clock and reset ports:
- fclk  in  1  clock.
- ayres_n  in  1  async active-low reset.
REQ-006 AY-side ports:
- bdir, bc1  in  1 each  raw AY bus control.
- asel  in  1  AY chip qualifier (bc2 & a8 & !a9_n), raw.
- ayd_in  in  8  AY data bus in.
- ayd_out  out  8  read data.
- ayd_oe  out  1  AY data bus drive enable.
REQ-007 Mode inputs: mode_enable_saa, mode_enable_ymfm  in  1 each  static, sampled every cycle.
REQ-008 Internal bus ports:
- d_in  in  8  internal bus in.
- d_out  out  8  internal bus out.
- d_oe  out  1  internal bus drive enable.
REQ-009 YM ports: ymcs1_n, ymcs2_n, ymrd_n, ymwr_n, yma0  out  1 each.
REQ-010 SAA ports: saacs_n, saawr_n, saaa0  out  1 each.
REQ-011 Status port: busy  out  1  high whenever state != IDLE.

Function
REQ-012 Synchroniser: bdir, bc1, asel through 2-flop synchronisers; code = {bdir,bc1} when synced asel=1, else 00.
REQ-013 Code decode: 11 = address write, 10 = data write, 01 = read, 00 = idle.
REQ-014 Start condition: in IDLE, first cycle of nonzero code latches op and ayd_in, enters SETUP.
REQ-015 Config writes: address write with value 8'hF8..8'hFF is a config write; sets chip_sel = value[0] (forced 0 if mode_enable_ymfm=0) and rd_stat = value[1]; clears saa_mode; no chip strobe; goes directly to WAIT_IDLE.
REQ-016 SAA select: address write 8'hF7 with mode_enable_saa=1 sets saa_mode=1, no strobe; with mode_enable_saa=0 it is a normal address write.
REQ-017 Target select: the target is SAA if saa_mode=1, else YM chip_sel (0 = ymcs1_n, 1 = ymcs2_n).
REQ-018 Address lines: YM a0 = 0 on address write, 1 on data write, ~rd_stat on read; SAA a0 = 1 on address write, 0 on data write.
REQ-019 FSM states: IDLE -> SETUP (T_SETUP) -> STROBE (T_PULSE) -> HOLD (T_HOLD) -> WAIT_IDLE; single down-counter loaded on each state entry.
REQ-020 Chip-select and address timing: cs_n low and a0 valid from SETUP through HOLD inclusive; wr_n/rd_n low only in STROBE.
REQ-021 Write drive: on writes, d_oe=1 and d_out=latched byte from SETUP through HOLD; d_oe=0 on reads and otherwise.
REQ-022 YM read: rd_latch captures d_in on last STROBE cycle.
REQ-023 SAA-mode read: no strobe issued; rd_latch=8'hFF.
REQ-024 Read data path: ayd_out = d_in during STROBE, else rd_latch.
REQ-025 Read drive enable: ayd_oe=1 while latched op is read and synced code==01, from SETUP until code leaves 01.
REQ-026 WAIT_IDLE exit: code 00 -> IDLE.
REQ-027 WAIT_IDLE back-to-back: nonzero code differing from the latched op starts a new op (next cycle SETUP, new ayd_in latched).
REQ-028 WAIT_IDLE hold: the same code keeps WAIT_IDLE.
REQ-029 Code changes during SETUP/STROBE/HOLD are ignored; the cycle always completes.
REQ-030 Exclusivity: at most one of ymcs1_n, ymcs2_n, saacs_n low at any time; no strobe ever low without its cs_n.

Reset
REQ-031 Asynchronous reset values: all cs_n/wr_n/rd_n=1, yma0=saaa0=0, d_oe=ayd_oe=0, d_out=0, rd_latch=8'hFF, chip_sel=0, rd_stat=0, saa_mode=0, state IDLE, synchronisers 0.
REQ-032 Reset asserted mid-cycle releases all strobes the same instant; no partial cycle resumes after release.

Structure
REQ-033 Shared package ay_seq_pkg holds: state enum, op codes, config constants 8'hF7 and 8'hF8 mask, and default timing values.
REQ-034 Sub-module ay_sync (2-flop bit synchroniser, async reset), instantiated three times.

Verification
REQ-035 Scenario SAA write: mode_enable_saa=1, write 8'hF7 to FFFD, then write 8'h5A to FFFD and 8'hC3 to BFFD -> SAA sees adr 8'h5A with saaa0=1 and dat 8'hC3 with saaa0=0; YM cs_n stays high.
REQ-036 Scenario YM chip 0 write: write 8'hFE, then 8'h27 to FFFD and 8'h81 to BFFD -> ymcs1_n strobes; YM0 adr=8'h27, data=8'h81; strobe low exactly 4 fclk cycles.
REQ-037 Scenario YM chip 1 read: write 8'hFD, then read FFFD with YM1 data 8'h3C -> yma0=1, ymcs2_n/ymrd_n pulse, ayd_out=8'h3C with ayd_oe=1 at the Z80 sample edge.
REQ-038 Scenario YMFM disabled: mode_enable_ymfm=0, write 8'hFF, then write 8'h10/8'h22 -> only ymcs1_n strobes; write 8'hF7 with mode_enable_saa=0 -> forwarded as YM address 8'hF7.
REQ-039 Scenario reset mid-cycle: ayres_n low during STROBE -> ymwr_n and ymcs1_n high within same timestep, busy=0, rd_latch=8'hFF.
REQ-040 Scenario back-to-back: code 11->10 with no 00 gap -> two full cycles, second begins one cycle after WAIT_IDLE entry, cs_n high for at least 1 cycle between them.
